// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state and error encodings for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    // Illegal funct3 takes priority over misalignment.
    function automatic err_e check_access(input logic is_store, input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic legal;
        if (is_store) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        if (!legal) return ERR_ILLEGAL;
        if ((funct3[1:0] == 2'b01) && off[0]) return ERR_MISALIGN;
        if ((funct3[1:0] == 2'b10) && (off != 2'b00)) return ERR_MISALIGN;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: byte enables, replicated store data, extended load data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_in,
    input  logic [1:0]  off_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be_out,
    output logic [31:0] wdata_out,
    output logic [31:0] load_val_out
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    always_comb begin
        byte_lane    = rdata_in[7:0];
        half_lane    = off_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        sign_ext     = ~funct3_in[2];
        be_out       = 4'b1111;
        wdata_out    = store_data_in;
        load_val_out = rdata_in;

        case (off_in)
            2'd1:    byte_lane = rdata_in[15:8];
            2'd2:    byte_lane = rdata_in[23:16];
            2'd3:    byte_lane = rdata_in[31:24];
            default: byte_lane = rdata_in[7:0];
        endcase

        case (funct3_in[1:0])
            2'b00: begin
                be_out       = 4'b0001 << off_in;
                wdata_out    = {4{store_data_in[7:0]}};
                load_val_out = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            2'b01: begin
                be_out       = 4'b0011 << off_in;
                wdata_out    = {2{store_data_in[15:0]}};
                load_val_out = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: begin
                be_out       = 4'b1111;
                wdata_out    = store_data_in;
                load_val_out = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: one load or store per start over a req/ack port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        is_store_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] load_data_out,
    output logic [1:0]  err_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [3:0]  mem_be_out,
    output logic [31:0] mem_wdata_out,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_ack_in
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    err_e        acc_err;
    logic        in_req;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_val;

    assign acc_err = check_access(is_store_in, funct3_in, addr_in[1:0]);

    lsu_align u_align (
        .funct3_in     (funct3_q),
        .off_in        (addr_q[1:0]),
        .store_data_in (store_data_q),
        .rdata_in      (mem_rdata_in),
        .be_out        (be),
        .wdata_out     (wdata),
        .load_val_out  (load_val)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            load_data_q  <= '0;
            err_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            load_data_q  <= load_data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        load_data_d  = load_data_q;
        err_d        = err_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    is_store_d   = is_store_in;
                    funct3_d     = funct3_in;
                    addr_d       = addr_in;
                    store_data_d = store_data_in;
                    cnt_d        = '0;
                    if (acc_err != ERR_OK) begin
                        err_d   = acc_err;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ack_in) begin
                    if (!is_store_q) load_data_d = load_val;
                    err_d   = ERR_OK;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs are decoded from state so reset drops them immediately.
    assign in_req        = (state_q == ST_REQ);
    assign busy_out      = (state_q != ST_IDLE);
    assign done_out      = (state_q == ST_DONE);
    assign load_data_out = load_data_q;
    assign err_out       = err_q;
    assign mem_req_out   = in_req;
    assign mem_we_out    = in_req & is_store_q;
    assign mem_addr_out  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be_out    = in_req ? be : '0;
    assign mem_wdata_out = in_req ? wdata : '0;

endmodule
